// File: rtl/led_matrix_scan.sv
// Row-multiplexed scan driver for an 8x8 LED matrix with double-buffered
// frame storage. The front buffer is scanned one row per slot, each slot
// opening with a blanking window to suppress ghosting. The back buffer
// takes writes, and the two buffers exchange roles only at a frame
// boundary so a frame is never torn by a swap.
module led_matrix_scan #(
    parameter int scan_divider = 100000,
    parameter int blank_cycles = 1000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       wr_en,
    input  logic [2:0] wr_row,
    input  logic [7:0] wr_data,
    input  logic       swap_req,
    output logic       swap_pending,
    output logic       swap_done,
    output logic       frame_start,
    output logic [7:0] rows,
    output logic [7:0] cols
);

    localparam int            CW        = (scan_divider > 1) ? $clog2(scan_divider) : 1;
    localparam logic [CW-1:0] cnt_max   = CW'(scan_divider - 1);
    localparam logic [CW-1:0] blank_end = CW'(blank_cycles);
    localparam logic [CW-1:0] cnt_one   = CW'(1);

    typedef enum logic {BLANK, DRIVE} scan_state_t;

    scan_state_t   state;
    scan_state_t   state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [2:0]    row;
    logic [2:0]    row_next;
    logic          sel;
    logic          sel_next;
    logic          slot_wrap;
    logic          frame_wrap;
    logic          swap_apply;
    logic          pending_next;
    logic [7:0]    front_row;
    logic [7:0]    rows_next;
    logic [7:0]    cols_next;
    logic [7:0]    buf0 [8];
    logic [7:0]    buf1 [8];

    // Next-state logic for the slot counter, row index, buffer select, swap
    // handshake and the BLANK/DRIVE phase, plus the registered drive values.
    // The phase flips to BLANK when a slot restarts and to DRIVE once the
    // blanking window has elapsed. The drive values are formed from the
    // post-edge counter, row and select so the pins move with the counter.
    // The front row is read from the current buffer contents: the only edge
    // on which that buffer can also change (a write landing on the applying
    // wrap) starts a new slot and therefore always drives blank.
    always_comb begin
        slot_wrap    = (cnt == cnt_max);
        cnt_next     = slot_wrap ? '0 : cnt + cnt_one;
        row_next     = slot_wrap ? row + 3'd1 : row;
        frame_wrap   = slot_wrap && (row == 3'd7);
        swap_apply   = frame_wrap && swap_pending;
        sel_next     = sel ^ swap_apply;
        pending_next = swap_apply ? swap_req : (swap_pending | swap_req);

        state_next = state;
        if (cnt_next == '0) begin
            state_next = BLANK;
        end else if (cnt_next == blank_end) begin
            state_next = DRIVE;
        end

        front_row = sel_next ? buf1[row_next] : buf0[row_next];
        rows_next = 8'h00;
        cols_next = 8'h00;
        if (state_next == DRIVE) begin
            rows_next = 8'h01 << row_next;
            cols_next = front_row;
        end
    end

    // Scan state register: counter, row, phase, select, swap handshake and
    // all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= BLANK;
            cnt          <= '0;
            row          <= 3'd0;
            sel          <= 1'b0;
            swap_pending <= 1'b0;
            swap_done    <= 1'b0;
            frame_start  <= 1'b0;
            rows         <= 8'h00;
            cols         <= 8'h00;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            row          <= row_next;
            sel          <= sel_next;
            swap_pending <= pending_next;
            swap_done    <= swap_apply;
            frame_start  <= frame_wrap;
            rows         <= rows_next;
            cols         <= cols_next;
        end
    end

    // Frame storage: writes always go to the back buffer selected by the
    // pre-edge select, so a write on the swapping edge lands in the buffer
    // that becomes front on that same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) begin
                buf0[i] <= 8'h00;
                buf1[i] <= 8'h00;
            end
        end else if (wr_en) begin
            if (sel) begin
                buf0[wr_row] <= wr_data;
            end else begin
                buf1[wr_row] <= wr_data;
            end
        end
    end

endmodule
